// File: rtl/wave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wave_pkg
//  Brief    : Shared types and constants for the enemy wave spawn controller.
//  Revision : 1.0 - initial release
// ============================================================================
package wave_pkg;

  // Controller FSM encodings, visible on the state output
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } wave_state_t;

  localparam int              LFSR_W      = 8;
  // Taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0]      DENSITY_MAX = 8'd240;
  localparam logic [7:0]      WAVE_MAX    = 8'd255;

  // An all-zero LFSR would lock up forever, so zero is remapped to 1
  function automatic logic [LFSR_W-1:0] guard_zero(input logic [LFSR_W-1:0] v);
    return (v == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : wave_lfsr
//  Brief    : 8-bit Fibonacci LFSR (shift left, feedback into bit 0) with
//             seed load, single-step advance and optional zero guard.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_lfsr
  import wave_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  input  logic              zero_guard,
  output logic [LFSR_W-1:0] value,
  output logic [LFSR_W-1:0] next_value
);

  localparam logic [LFSR_W-1:0] RESET_VALUE = guard_zero(SEED);

  logic [LFSR_W-1:0] r_value;
  logic [LFSR_W-1:0] w_stepped;
  logic [LFSR_W-1:0] w_seed;

  assign w_stepped  = {r_value[LFSR_W-2:0], ^(r_value & LFSR_TAPS)};
  assign next_value = zero_guard ? guard_zero(w_stepped) : w_stepped;
  assign w_seed     = zero_guard ? guard_zero(seed) : seed;
  assign value      = r_value;

  // Load has priority over step so a restart always begins from the seed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= RESET_VALUE;
    end else if (load) begin
      r_value <= w_seed;
    end else if (step) begin
      r_value <= next_value;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wave_spawn_controller.sv
`default_nettype none
// ============================================================================
//  Module   : wave_spawn_controller
//  Brief    : Drives D / enable / force_0 of the enemy cell row: one shift
//             pulse per game tick, LFSR-driven spawn bit, row-clear pulses
//             kept apart from shift pulses, and per-wave density escalation.
//  Revision : 1.0 - initial release
// ============================================================================
module wave_spawn_controller
  import wave_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 25000000,
  parameter int unsigned WAVE_LEN     = 16,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter int unsigned DENSITY_INIT = 64,
  parameter int unsigned DENSITY_STEP = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       game_over,
  output logic       spawn_d,
  output logic       shift_en,
  output logic       clear_row,
  output logic [7:0] wave_num,
  output logic [1:0] state
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SHIFT_W = (WAVE_LEN > 1) ? $clog2(WAVE_LEN) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(WAVE_LEN - 1);
  localparam logic [7:0]         DENS_INIT  = 8'(DENSITY_INIT);
  localparam logic [8:0]         DENS_STEP  = 9'(DENSITY_STEP);

  wave_state_t        r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic [SHIFT_W-1:0] r_shift_cnt;
  logic [7:0]         r_density;
  logic [7:0]         r_wave_num;
  logic               r_clear_pend;
  logic               r_spawn_d;
  logic               r_shift_en;
  logic               r_clear_row;

  logic               w_reload;
  logic               w_active;
  logic               w_tick;
  logic [7:0]         w_lfsr;
  logic [7:0]         w_lfsr_next;
  logic [8:0]         w_dens_sum;
  logic [7:0]         w_dens_next;
  logic [7:0]         w_wave_next;

  // Play (re)starts from IDLE or OVER; normal work happens only in an
  // undisturbed RUN cycle (pause and game_over both pre-empt the tick)
  assign w_reload = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && start;
  assign w_active = (r_state == ST_RUN) && !pause && !game_over;
  assign w_tick   = w_active && (r_tick_cnt == TICK_LAST);

  // Density escalates with 9-bit headroom so the clamp sees any overflow
  assign w_dens_sum  = {1'b0, r_density} + DENS_STEP;
  assign w_dens_next = (w_dens_sum > {1'b0, DENSITY_MAX}) ? DENSITY_MAX : w_dens_sum[7:0];
  assign w_wave_next = (r_wave_num == WAVE_MAX) ? WAVE_MAX : r_wave_num + 8'd1;

  wave_lfsr #(
    .SEED       (SEED)
  ) u_lfsr (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (w_reload),
    .step       (w_tick),
    .seed       (SEED),
    .zero_guard (1'b1),
    .value      (w_lfsr),
    .next_value (w_lfsr_next)
  );

  // FSM, tick/shift counters, escalation and clear arbitration
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_shift_cnt  <= '0;
      r_density    <= DENS_INIT;
      r_wave_num   <= 8'd0;
      r_clear_pend <= 1'b0;
      r_spawn_d    <= 1'b0;
      r_shift_en   <= 1'b0;
      r_clear_row  <= 1'b0;
    end else begin
      r_shift_en  <= 1'b0;
      r_clear_row <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          r_tick_cnt <= '0;
          if (start) begin
            r_state      <= ST_RUN;
            r_shift_cnt  <= '0;
            r_density    <= DENS_INIT;
            r_wave_num   <= 8'd0;
            r_clear_pend <= 1'b0;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            r_state      <= ST_OVER;
            r_tick_cnt   <= '0;
            r_clear_pend <= 1'b0;
          end else if (pause) begin
            r_state <= ST_PAUSED;
          end else begin
            if (w_tick) begin
              r_tick_cnt <= '0;
              r_shift_en <= 1'b1;
              r_spawn_d  <= (w_lfsr_next < r_density);
              if (r_shift_cnt == SHIFT_LAST) begin
                r_shift_cnt <= '0;
                r_wave_num  <= w_wave_next;
                r_density   <= w_dens_next;
              end else begin
                r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
            // A cell ignores force_0 while enabled, so a clear landing on a
            // shift cycle is parked and issued on the following cycle
            if (hit || r_clear_pend) begin
              if (w_tick) begin
                r_clear_pend <= 1'b1;
              end else begin
                r_clear_row  <= 1'b1;
                r_clear_pend <= 1'b0;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (game_over) begin
            r_state      <= ST_OVER;
            r_tick_cnt   <= '0;
            r_clear_pend <= 1'b0;
          end else if (!pause) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign spawn_d   = r_spawn_d;
  assign shift_en  = r_shift_en;
  assign clear_row = r_clear_row;
  assign wave_num  = r_wave_num;
  assign state     = r_state;

endmodule
`default_nettype wire
